// File: rtl/axis_counter_v2.sv
// AXI4-Stream counter pattern generator: bursts of NLANES-lane beats with programmable step, mode, gap and repeat.
// First beat is valid one cycle after start; a presented beat is held unchanged until m_axis_tready accepts it.
module axis_counter_v2 #(
  parameter int BDATA  = 16,
  parameter int BUSER  = 8,
  parameter int NLANES = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    START_REG,
  input  logic [31:0]             NDATA_REG,
  input  logic [31:0]             NUSER_REG,
  input  logic [31:0]             WAIT_REG,
  input  logic [BDATA-1:0]        STEP_REG,
  input  logic [31:0]             NREP_REG,
  input  logic [2:0]              MODE_REG,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [NLANES*BDATA-1:0] m_axis_tdata,
  output logic [BUSER-1:0]        m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    done_pulse
);
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  // Run configuration frozen at the start edge; delta is the signed per-sample increment.
  typedef struct packed {
    logic [31:0]      ndata;
    logic [31:0]      waitc;
    logic [31:0]      nrep;
    logic [BDATA-1:0] delta;
    logic             cont;
  } cfg_t;

  state_t           state;
  cfg_t             cfg;
  logic             start_q;
  logic             stop_q;
  logic [31:0]      beat_cnt;
  logic [31:0]      burst_cnt;
  logic [31:0]      gap_cnt;
  logic [BDATA-1:0] acc;

  logic             start_edge;
  logic             hs;
  logic             last_burst;
  logic [BDATA-1:0] acc_next;
  logic [BDATA-1:0] burst_base;
  logic             unused_nuser;

  function automatic logic [BDATA-1:0] delta_of(input logic [2:0] mode, input logic [BDATA-1:0] step);
    case (mode[1:0])
      2'd1:    delta_of = '0 - step;
      2'd2:    delta_of = '0;
      default: delta_of = step;
    endcase
  endfunction

  function automatic logic [NLANES*BDATA-1:0] lanes(input logic [BDATA-1:0] v0, input logic [BDATA-1:0] d);
    logic [BDATA-1:0] v;
    v = v0;
    for (int i = 0; i < NLANES; i++) begin
      lanes[i*BDATA +: BDATA] = v;
      v = v + d;
    end
  endfunction

  assign start_edge   = (state == IDLE) && START_REG && !start_q;
  assign hs           = m_axis_tvalid && m_axis_tready;
  assign acc_next     = acc + BDATA'(NLANES) * cfg.delta;
  assign last_burst   = (cfg.nrep != 32'd0) && (burst_cnt == cfg.nrep - 32'd1);
  assign burst_base   = cfg.cont ? acc_next : '0;
  assign busy         = (state != IDLE);
  assign unused_nuser = ^NUSER_REG[31:BUSER];

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      cfg           <= '0;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      beat_cnt      <= '0;
      burst_cnt     <= '0;
      gap_cnt       <= '0;
      acc           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      done_pulse    <= 1'b0;
    end else begin
      start_q    <= START_REG;
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            cfg.ndata    <= NDATA_REG;
            cfg.waitc    <= WAIT_REG;
            cfg.nrep     <= NREP_REG;
            cfg.delta    <= delta_of(MODE_REG, STEP_REG);
            cfg.cont     <= MODE_REG[2];
            m_axis_tuser <= NUSER_REG[BUSER-1:0];
            m_axis_tdata <= lanes('0, delta_of(MODE_REG, STEP_REG));
            stop_q       <= 1'b0;
            beat_cnt     <= '0;
            burst_cnt    <= '0;
            acc          <= '0;
            if (NDATA_REG == 32'd0) begin
              done_pulse <= 1'b1;
            end else begin
              state         <= RUN;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= (NDATA_REG == 32'd1);
            end
          end
        end
        RUN: begin
          // A stop request is remembered so the pending beat can still finish its handshake.
          if (!START_REG) stop_q <= 1'b1;
          if (hs) begin
            if (stop_q || !START_REG || (m_axis_tlast && last_burst)) begin
              state         <= IDLE;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              done_pulse    <= 1'b1;
            end else if (m_axis_tlast) begin
              burst_cnt    <= burst_cnt + 32'd1;
              beat_cnt     <= '0;
              acc          <= burst_base;
              m_axis_tdata <= lanes(burst_base, cfg.delta);
              m_axis_tlast <= (cfg.ndata == 32'd1);
              if (cfg.waitc != 32'd0) begin
                state         <= GAP;
                m_axis_tvalid <= 1'b0;
                gap_cnt       <= '0;
              end
            end else begin
              beat_cnt     <= beat_cnt + 32'd1;
              acc          <= acc_next;
              m_axis_tdata <= lanes(acc_next, cfg.delta);
              m_axis_tlast <= (beat_cnt + 32'd2 == cfg.ndata);
            end
          end
        end
        GAP: begin
          if (!START_REG) begin
            state      <= IDLE;
            done_pulse <= 1'b1;
          end else if (gap_cnt == cfg.waitc - 32'd1) begin
            state         <= RUN;
            m_axis_tvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
